if_prefetch_unit: RTL

//   Instruction fetch front end upstream of IF/ID. Holds the fetch PC and issues in-order requests to

---
 rtl/if_prefetch_unit_if.sv | 25 ++
 rtl/if_prefetch_unit.sv | 139 +++++++++++++
 2 files changed

// File: rtl/if_prefetch_unit_if.sv
// Instruction memory bus: in-order req/gnt requests, rvalid responses.
// master = fetch unit, slave = instruction memory.
interface if_prefetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/if_prefetch_unit.sv
// Fetch front end: PC, credit-limited imem requests, prefetch FIFO,
// redirect flush with discard of in-flight words.
module if_prefetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  if_prefetch_unit_if.master        imem,
  input  logic                      redirect_valid,
  input  logic [31:0]               redirect_pc,
  input  logic                      stall,
  output logic                      instr_valid,
  output logic [31:0]               instr,
  output logic [31:0]               instr_pc
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW+1:0] DEPTH_C = (CW+2)'(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  entry_t        fifo_q [DEPTH];
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] outstanding_q;
  logic [CW-1:0] discard_q;
  logic [31:0]   fetch_pc_q;
  logic [31:0]   resp_pc_q;
  logic [31:0]   pend_pc_q;
  logic          pend_redir_q;
  logic          rst_q;

  logic [CW+1:0] credit;
  logic          accept;
  logic          rsp_drop;
  logic          rsp_keep;
  logic          push;
  logic          pop;
  logic [31:0]   target;
  logic          unused_pc_lsb;

  assign unused_pc_lsb = ^redirect_pc[1:0];
  assign target = {redirect_pc[31:2], 2'b00};

  assign credit = {2'b00, count_q}
                + {2'b00, outstanding_q}
                + {2'b00, discard_q};

  assign imem.imem_req  = !rst_q && (credit < DEPTH_C);
  assign imem.imem_addr = fetch_pc_q;

  assign accept   = imem.imem_req && imem.imem_gnt;
  assign rsp_drop = imem.imem_rvalid && (discard_q != '0);
  assign rsp_keep = imem.imem_rvalid && (discard_q == '0)
                 && (outstanding_q != '0);

  assign push = rsp_keep && !redirect_valid;
  assign pop  = instr_valid && !stall && !redirect_valid;

  assign instr_valid = (count_q != '0);
  assign instr    = instr_valid ? fifo_q[rd_ptr_q].word : NOP;
  assign instr_pc = instr_valid ? fifo_q[rd_ptr_q].pc : '0;

  // Delayed reset keeps the request line low for the first cycle out of reset
  always_ff @(posedge clk) begin
    rst_q <= rst;
  end

  // Fetch PC, response PC and in-flight accounting
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      pend_pc_q     <= '0;
      pend_redir_q  <= 1'b0;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else if (redirect_valid) begin
      discard_q <= discard_q + outstanding_q
                 + CW'(accept)
                 - CW'(rsp_drop | rsp_keep);
      outstanding_q <= '0;
      resp_pc_q     <= target;
      if (imem.imem_req && !imem.imem_gnt) begin
        pend_redir_q <= 1'b1;
        pend_pc_q    <= target;
      end else begin
        pend_redir_q <= 1'b0;
        fetch_pc_q   <= target;
      end
    end else begin
      if (accept) begin
        fetch_pc_q   <= pend_redir_q ? pend_pc_q
                                     : fetch_pc_q + 32'd4;
        pend_redir_q <= 1'b0;
      end
      discard_q <= discard_q
                 + CW'(accept && pend_redir_q)
                 - CW'(rsp_drop);
      outstanding_q <= outstanding_q
                     + CW'(accept && !pend_redir_q)
                     - CW'(rsp_keep);
      if (rsp_keep) resp_pc_q <= resp_pc_q + 32'd4;
    end
  end

  // FIFO pointers and occupancy; redirect flushes everything
  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage, written only when a kept word arrives
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_q[wr_ptr_q] <= '{pc: resp_pc_q, word: imem.imem_rdata};
    end
  end

  ap_no_spurious_rsp: assert property (
    @(posedge clk) disable iff (rst)
    !(imem.imem_rvalid && outstanding_q == '0 && discard_q == '0)
  );

endmodule
